// File: rtl/monopix_pkg.sv
// Shared types and helpers for the Monopix column-drain readout sequencer.
package monopix_pkg;

  localparam int unsigned COL_W  = 6;
  localparam int unsigned ROW_W  = 8;
  localparam int unsigned LE_W   = 6;
  localparam int unsigned TE_W   = 6;
  localparam int unsigned HIT_W  = COL_W + ROW_W + LE_W + TE_W;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_READ,
    ST_SHIFT,
    ST_PUSH,
    ST_WAIT_ACK,
    ST_SETTLE,
    ST_HOLD
  } state_t;

  typedef struct packed {
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [LE_W-1:0]  le;
    logic [TE_W-1:0]  te;
  } hit_t;

  function automatic logic [WORD_W-1:0] pack_word(input hit_t hit);
    return {{(WORD_W - HIT_W){1'b0}}, hit.col, hit.row, hit.le, hit.te};
  endfunction

endpackage

// File: rtl/cdc_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous chip pin.
module cdc_sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/monopix_readout_seq.sv
// Token-driven FREEZE/READ/CLK_OUT sequencer that deserialises each chip hit
// into one 32-bit word on a valid/ready stream.
module monopix_readout_seq
  import monopix_pkg::*;
#(
  parameter int unsigned DATA_BITS    = 26,
  parameter int unsigned FREEZE_SETUP = 4,
  parameter int unsigned READ_HIGH    = 2,
  parameter int unsigned TOKEN_SETTLE = 6,
  parameter int unsigned FREEZE_HOLD  = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ENABLE,
  input  logic        TOKEN,
  input  logic        DATA,
  output logic        FREEZE,
  output logic        READ,
  output logic        CLK_OUT,
  output logic [31:0] WORD_DATA,
  output logic        WORD_VALID,
  input  logic        WORD_READY,
  output logic        BUSY,
  output logic [15:0] HIT_COUNT
);

  localparam int unsigned SHIFT_LEN = 2 * DATA_BITS + 2;
  localparam int unsigned CNT_W =
    $clog2(SHIFT_LEN + FREEZE_SETUP + READ_HIGH + TOKEN_SETTLE + FREEZE_HOLD + 1);

  logic tok_s;
  logic data_s;

  cdc_sync_2ff u_sync_token (
    .clk (CLK),
    .rst (RST),
    .d   (TOKEN),
    .q   (tok_s)
  );

  cdc_sync_2ff u_sync_data (
    .clk (CLK),
    .rst (RST),
    .d   (DATA),
    .q   (data_s)
  );

  state_t             state_q, state_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;
  logic               freeze_q, read_q, clk_out_q, clk_out_nxt;
  logic [DATA_BITS-1:0] shreg_q;
  logic [31:0]        word_q;
  logic               valid_q;
  logic [15:0]        hit_count_q;
  logic               load_word, ack, sample_bit;

  // CLK_OUT falls on odd counts; the synchroniser delays the pin by two
  // cycles, so the matching bit is taken two counts later (3, 5, ... 53).
  assign sample_bit = (state_q == ST_SHIFT) && cnt_q[0] && (cnt_q >= CNT_W'(3));

  always_comb begin
    state_nxt   = state_q;
    cnt_nxt     = cnt_q + 1'b1;
    clk_out_nxt = 1'b0;
    load_word   = 1'b0;
    ack         = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (ENABLE && tok_s) state_nxt = ST_SETUP;
      end
      ST_SETUP: begin
        if (cnt_q == CNT_W'(FREEZE_SETUP - 1)) begin
          state_nxt = ST_READ;
          cnt_nxt   = '0;
        end
      end
      ST_READ: begin
        if (cnt_q == CNT_W'(READ_HIGH - 1)) begin
          state_nxt = ST_SHIFT;
          cnt_nxt   = '0;
        end
      end
      ST_SHIFT: begin
        if (cnt_q < CNT_W'(2 * DATA_BITS)) clk_out_nxt = ~clk_out_q;
        if (cnt_q == CNT_W'(SHIFT_LEN - 1)) begin
          state_nxt = ST_PUSH;
          cnt_nxt   = '0;
        end
      end
      ST_PUSH: begin
        cnt_nxt   = '0;
        load_word = 1'b1;
        state_nxt = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        cnt_nxt = '0;
        if (WORD_READY) begin
          ack       = 1'b1;
          state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_W'(TOKEN_SETTLE - 1)) begin
          cnt_nxt   = '0;
          state_nxt = (tok_s && ENABLE) ? ST_READ : ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cnt_q == CNT_W'(FREEZE_HOLD - 1)) begin
          cnt_nxt   = '0;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Pin outputs are registered from the next state so the chip never sees
  // decode glitches.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      freeze_q  <= 1'b0;
      read_q    <= 1'b0;
      clk_out_q <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      cnt_q     <= cnt_nxt;
      freeze_q  <= (state_nxt != ST_IDLE);
      read_q    <= (state_nxt == ST_READ);
      clk_out_q <= clk_out_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      shreg_q     <= '0;
      word_q      <= '0;
      valid_q     <= 1'b0;
      hit_count_q <= '0;
    end else begin
      if (state_q == ST_READ) shreg_q <= '0;
      else if (sample_bit) shreg_q <= {shreg_q[DATA_BITS-2:0], data_s};
      if (load_word) begin
        word_q  <= pack_word(hit_t'(shreg_q));
        valid_q <= 1'b1;
      end
      if (ack) begin
        valid_q <= 1'b0;
        if (hit_count_q != '1) hit_count_q <= hit_count_q + 1'b1;
      end
    end
  end

  assign FREEZE     = freeze_q;
  assign READ       = read_q;
  assign CLK_OUT    = clk_out_q;
  assign WORD_DATA  = word_q;
  assign WORD_VALID = valid_q;
  assign BUSY       = (state_q != ST_IDLE);
  assign HIT_COUNT  = hit_count_q;

endmodule

// File: doc/monopix_readout_seq.md
Name: monopix_readout_seq

Overview:
FPGA-side sequencer for the Monopix column-drain readout. It watches TOKEN from the chip and drives FREEZE, READ and a divided CLK_OUT. It deserialises each hit from the chip's DATA pin into one 32-bit word and presents it on a valid/ready stream to the data FIFO. It sits between the chip pins and the readout FIFO inside monopix_mio.

Parameters:
DATA_BITS, 26, serial bits per hit (col 6 | row 8 | LE 6 | TE 6, MSB first)
FREEZE_SETUP, 4, CLK cycles between FREEZE rise and first READ
READ_HIGH, 2, CLK cycles READ stays high per hit
TOKEN_SETTLE, 6, CLK cycles after a hit before TOKEN is re-sampled
FREEZE_HOLD, 2, CLK cycles FREEZE stays high after the last hit

Ports:
CLK  in  1  readout clock; CLK_OUT = CLK/2
RST  in  1  synchronous reset, active high
ENABLE  in  1  allow new readout cycles
TOKEN  in  1  chip token, asynchronous
DATA  in  1  chip serial data, asynchronous
FREEZE  out  1  freeze chip hit buffers
READ  out  1  per-hit read strobe to chip
CLK_OUT  out  1  serial shift clock to chip
WORD_DATA  out  32  {6'b0, hit[25:0]}
WORD_VALID  out  1  word available
WORD_READY  in  1  consumer accepts
BUSY  out  1  high in any state except IDLE
HIT_COUNT  out  16  hits read since reset, saturating at 16'hFFFF

Behaviour:
- Interface (already decided): one clock, CLK; RST is synchronous and active-high.
- Reset values: FREEZE=0, READ=0, CLK_OUT=0, WORD_VALID=0, WORD_DATA=0, BUSY=0, HIT_COUNT=0. All counters are cleared and the FSM goes to IDLE.
- RST asserted mid-operation aborts immediately. The outputs above take their reset values on the next edge, and a partial word is discarded.
- TOKEN and DATA each pass through a 2-FF synchroniser. Every TOKEN reference below means tok_s, the synchronised value.
- FSM states and transitions:
  - IDLE: if ENABLE & tok_s, set FREEZE=1 and go to SETUP.
  - SETUP: wait FREEZE_SETUP cycles, then go to READ.
  - READ: READ=1 for READ_HIGH cycles, then READ=0 and go to SHIFT.
  - SHIFT: CLK_OUT toggles every CLK cycle. DATA is sampled on the CLK edge where CLK_OUT goes 1->0 (chip launches on CLK_OUT rise).
    - The sample is taken 2 cycles late to cover the synchroniser; these cycles are counted in.
    - After DATA_BITS samples, force CLK_OUT=0 and go to PUSH.
  - PUSH: load WORD_DATA, set WORD_VALID=1, go to WAIT_ACK.
  - WAIT_ACK: hold WORD_DATA and WORD_VALID until WORD_READY. On the handshake, clear WORD_VALID, increment HIT_COUNT, go to SETTLE.
  - SETTLE: wait TOKEN_SETTLE cycles. Then, if tok_s & ENABLE, go to READ; otherwise go to HOLD.
  - HOLD: keep FREEZE=1 for FREEZE_HOLD cycles, drop FREEZE, go to IDLE.
- Backpressure: WORD_READY low stalls in WAIT_ACK indefinitely. FREEZE stays high and no new READ is issued, so no hit is lost.
- WORD_VALID may rise while WORD_READY is already high. The handshake then completes on the first cycle WORD_VALID is high.
- ENABLE dropping mid-hit: the current hit completes (shift, push, ack). The FSM then takes the SETTLE->HOLD path.
- Simultaneous events: TOKEN rising while the FSM is in HOLD is ignored until IDLE, which adds a minimum 1-cycle gap.
- HIT_COUNT saturates at 16'hFFFF and does not wrap.
- Per-hit latency in CLK cycles, from READ rise to WORD_VALID: READ_HIGH + 2*DATA_BITS + 2 + 1. With defaults this is 57.

Decomposition:
- Package monopix_pkg holds:
  - the state enum typedef;
  - field localparams COL_W=6, ROW_W=8, LE_W=6, TE_W=6;
  - HIT_W = their sum;
  - a function that packs a hit into WORD_DATA.
- Sub-module cdc_sync_2ff is instantiated twice, once for TOKEN and once for DATA.

Test Plan:
1. Single hit: TOKEN rises, chip model shifts 26'h2A5_5A5A and drops TOKEN after READ. Required: FREEZE then READ after 4+2 cycles. WORD_DATA = 32'h02A5_5A5A, WORD_VALID for 1 cycle with READY tied high. FREEZE falls FREEZE_HOLD cycles after SETTLE. HIT_COUNT = 1.
2. Burst of 3 hits with TOKEN held until the 3rd read. Required: 3 words in order, exactly 3 READ pulses, FREEZE high continuously across all three, HIT_COUNT = 3.
3. Backpressure: WORD_READY low for 100 cycles on hit 1. Required: WORD_DATA stable, no 2nd READ pulse during the stall; both words delivered after READY rises.
4. ENABLE dropped during SHIFT of hit 1 while TOKEN stays high. Required: hit 1 delivered, no further READ, FREEZE released, and the FSM stays IDLE.
5. RST pulsed in the middle of SHIFT. Required: all outputs at reset values on the next cycle, no WORD_VALID, HIT_COUNT = 0.
6. HIT_COUNT preloaded by force to 16'hFFFE, then 3 hits. Required: HIT_COUNT reads 16'hFFFF and stays there.
